// File: rtl/serial_word_comparator_if.sv
// Handshake and bit-stream bundle between the serial comparator, its operand
// source, its result sink and the external 1-bit compare stage.
interface serial_word_comparator_if #(
  parameter int WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic             bit_x;
  logic             bit_y;
  logic             bit_vld;
  logic             bit_eq;
  logic             out_valid;
  logic             out_ready;
  logic             res_eq;
  logic             res_gt;
  logic             res_lt;

  modport master (
    output in_valid, in_a, in_b, bit_eq, out_ready,
    input  in_ready, bit_x, bit_y, bit_vld, out_valid, res_eq, res_gt, res_lt
  );

  modport slave (
    input  in_valid, in_a, in_b, bit_eq, out_ready,
    output in_ready, bit_x, bit_y, bit_vld, out_valid, res_eq, res_gt, res_lt
  );
endinterface

// File: rtl/serial_word_comparator.sv
// Streams two operands MSB-first into an external 1-bit comparator and turns
// its per-bit equality flag into a one-hot eq/gt/lt result, stopping early.
module serial_word_comparator #(
  parameter int WIDTH = 8
) (
  input logic                      clk,
  input logic                      rst_n,
  serial_word_comparator_if.slave  bus
);
  localparam int CNT_W = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] sa;
  logic [WIDTH-1:0] sb;
  logic [CNT_W-1:0] cnt;
  logic             res_eq_q;
  logic             res_gt_q;
  logic             res_lt_q;
  logic             last_bit;

  assign last_bit = (cnt == CNT_W'(WIDTH - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    bus.in_ready  = 1'b0;
    bus.bit_vld   = 1'b0;
    bus.bit_x     = 1'b0;
    bus.bit_y     = 1'b0;
    bus.out_valid = 1'b0;
    case (state)
      IDLE: begin
        bus.in_ready = 1'b1;
        if (bus.in_valid) state_nxt = SHIFT;
      end
      SHIFT: begin
        bus.bit_vld = 1'b1;
        bus.bit_x   = sa[WIDTH-1];
        bus.bit_y   = sb[WIDTH-1];
        if (!bus.bit_eq || last_bit) state_nxt = DONE;
      end
      DONE: begin
        bus.out_valid = 1'b1;
        if (bus.out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // The first differing bit decides the result; the A bit alone gives its sign.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sa       <= '0;
      sb       <= '0;
      cnt      <= '0;
      res_eq_q <= 1'b0;
      res_gt_q <= 1'b0;
      res_lt_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            sa       <= bus.in_a;
            sb       <= bus.in_b;
            cnt      <= '0;
            res_eq_q <= 1'b0;
            res_gt_q <= 1'b0;
            res_lt_q <= 1'b0;
          end
        end
        SHIFT: begin
          if (!bus.bit_eq) begin
            res_gt_q <= sa[WIDTH-1];
            res_lt_q <= ~sa[WIDTH-1];
            res_eq_q <= 1'b0;
          end else if (last_bit) begin
            res_eq_q <= 1'b1;
          end else begin
            sa  <= sa << 1;
            sb  <= sb << 1;
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.res_eq = res_eq_q;
  assign bus.res_gt = res_gt_q;
  assign bus.res_lt = res_lt_q;
endmodule

// File: tb/tb_serial_word_comparator.sv
// Directed and randomized checks of serial_word_comparator at WIDTH=8 and
// WIDTH=1, with the 1-bit compare stage modelled inside the bench.
module tb_serial_word_comparator;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  serial_word_comparator_if #(.WIDTH(8)) bus8 ();
  serial_word_comparator_if #(.WIDTH(1)) bus1 ();

  serial_word_comparator #(.WIDTH(8)) dut8 (.clk(clk), .rst_n(rst_n), .bus(bus8));
  serial_word_comparator #(.WIDTH(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));

  int unsigned vectors = 0;
  int unsigned miscompares = 0;

  bit         narrow_sel = 1'b0;
  logic       drv_valid  = 1'b0;
  logic       drv_ready  = 1'b0;
  logic [7:0] drv_a      = '0;
  logic [7:0] drv_b      = '0;
  logic       junk_eq    = 1'b0;

  // The 1-bit stage is only trusted while bit_vld is high; otherwise feed noise.
  always @(negedge clk) junk_eq = 1'($urandom);

  assign bus8.in_valid  = drv_valid & ~narrow_sel;
  assign bus8.out_ready = drv_ready & ~narrow_sel;
  assign bus8.in_a      = drv_a;
  assign bus8.in_b      = drv_b;
  assign bus8.bit_eq    = bus8.bit_vld ? (bus8.bit_x == bus8.bit_y) : junk_eq;
  assign bus1.in_valid  = drv_valid & narrow_sel;
  assign bus1.out_ready = drv_ready & narrow_sel;
  assign bus1.in_a      = drv_a[0];
  assign bus1.in_b      = drv_b[0];
  assign bus1.bit_eq    = bus1.bit_vld ? (bus1.bit_x == bus1.bit_y) : ~junk_eq;

  logic o_in_ready, o_out_valid, o_bit_vld, o_bit_x, o_bit_y;
  logic [2:0] o_res;
  assign o_in_ready  = narrow_sel ? bus1.in_ready  : bus8.in_ready;
  assign o_out_valid = narrow_sel ? bus1.out_valid : bus8.out_valid;
  assign o_bit_vld   = narrow_sel ? bus1.bit_vld   : bus8.bit_vld;
  assign o_bit_x     = narrow_sel ? bus1.bit_x     : bus8.bit_x;
  assign o_bit_y     = narrow_sel ? bus1.bit_y     : bus8.bit_y;
  assign o_res = narrow_sel ? {bus1.res_eq, bus1.res_gt, bus1.res_lt}
                            : {bus8.res_eq, bus8.res_gt, bus8.res_lt};

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One full transaction: accept, bit stream, result, optional backpressure, release.
  task automatic applyStimulus(input logic [7:0] a, input logic [7:0] b,
                               input int stall, input string tag);
    int         w;
    int         lat;
    logic [7:0] mask;
    logic [7:0] am;
    logic [7:0] bm;
    logic [2:0] exp_res;
    w    = narrow_sel ? 1 : 8;
    mask = narrow_sel ? 8'h01 : 8'hFF;
    am   = a & mask;
    bm   = b & mask;
    exp_res = {am == bm, am > bm, am < bm};
    lat = w;
    for (int p = 0; p < w; p++) begin
      if (am[p] != bm[p]) lat = w - p;
    end

    checkOutput({tag, ".ready"}, 32'(o_in_ready), 32'd1);
    drv_a     = a;
    drv_b     = b;
    drv_valid = 1'b1;
    tick();
    drv_valid = 1'b0;
    for (int i = 0; i < lat; i++) begin
      checkOutput($sformatf("%s.shift%0d", tag, i),
                  {27'd0, o_bit_vld, o_bit_x, o_bit_y, o_in_ready, o_out_valid},
                  {27'd0, 1'b1, am[w-1-i], bm[w-1-i], 1'b0, 1'b0});
      tick();
    end
    checkOutput({tag, ".done"}, {28'd0, o_out_valid, o_bit_vld, o_in_ready, 1'b0},
                {28'd0, 1'b1, 1'b0, 1'b0, 1'b0});
    checkOutput({tag, ".res"}, 32'(o_res), 32'(exp_res));

    for (int s = 0; s < stall; s++) begin
      drv_a     = 8'h01;
      drv_b     = 8'h00;
      drv_valid = 1'b1;
      tick();
      checkOutput($sformatf("%s.hold%0d", tag, s),
                  {26'd0, o_out_valid, o_in_ready, 1'b0, o_res},
                  {26'd0, 1'b1, 1'b0, 1'b0, exp_res});
    end
    drv_ready = 1'b1;
    tick();
    drv_ready = 1'b0;
    drv_valid = 1'b0;
    checkOutput({tag, ".idle"}, {26'd0, o_out_valid, o_in_ready, 1'b0, o_res},
                {26'd0, 1'b0, 1'b1, 1'b0, exp_res});
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [7:0] ra;
    logic [7:0] rb;

    $display("[TB] start");
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset8", {24'd0, o_in_ready, o_out_valid, o_bit_vld, o_bit_x, o_bit_y, o_res},
                {24'd0, 8'b1000_0000});
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    applyStimulus(8'hA5, 8'hA5, 0, "eq_a5");
    applyStimulus(8'h80, 8'h7F, 0, "gt_msb");
    applyStimulus(8'h12, 8'h13, 0, "lt_lsb");
    applyStimulus(8'h40, 8'h00, 5, "backpressure");
    applyStimulus(8'h01, 8'h00, 0, "after_bp");

    // Abort a compare partway through the stream.
    drv_a     = 8'hFF;
    drv_b     = 8'hFF;
    drv_valid = 1'b1;
    tick();
    drv_valid = 1'b0;
    repeat (3) tick();
    checkOutput("pre_reset", 32'(o_bit_vld), 32'd1);
    rst_n = 1'b0;
    #1;
    checkOutput("async_reset", {24'd0, o_in_ready, o_out_valid, o_bit_vld, o_bit_x, o_bit_y, o_res},
                {24'd0, 8'b1000_0000});
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    checkOutput("post_reset", {30'd0, o_out_valid, o_in_ready}, {30'd0, 1'b0, 1'b1});
    applyStimulus(8'h01, 8'h02, 0, "fresh_lt");

    for (int n = 0; n < 24; n++) begin
      ra = 8'($urandom);
      case ($urandom_range(0, 3))
        0:       rb = ra;
        1:       rb = ra ^ (8'h01 << $urandom_range(0, 7));
        default: rb = 8'($urandom);
      endcase
      applyStimulus(ra, rb, int'($urandom_range(0, 2)), $sformatf("rand%0d", n));
    end

    narrow_sel = 1'b1;
    tick();
    applyStimulus(8'h01, 8'h00, 0, "w1_gt");
    applyStimulus(8'h01, 8'h01, 0, "w1_eq");
    applyStimulus(8'h00, 8'h01, 1, "w1_lt");
    applyStimulus(8'h00, 8'h00, 0, "w1_eq0");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
